// File: rtl/fsm_slave_arb_if.sv
// Bus bundle between the two per-master routing FSMs, the slave-side
// arbiter and the downstream slave. The arbiter uses the slave modport;
// the surrounding fabric (or a bench) uses the master modport.
interface fsm_slave_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  // master 1 request side
  logic                  req_m1;
  logic                  cmd_m1;
  logic [ADDR_WIDTH-1:0] addr_m1;
  logic [DATA_WIDTH-1:0] wdata_m1;
  logic                  ack_m1;
  logic [DATA_WIDTH-1:0] rdata_m1;
  // master 2 request side
  logic                  req_m2;
  logic                  cmd_m2;
  logic [ADDR_WIDTH-1:0] addr_m2;
  logic [DATA_WIDTH-1:0] wdata_m2;
  logic                  ack_m2;
  logic [DATA_WIDTH-1:0] rdata_m2;
  // single slave interface
  logic                  req_s;
  logic                  cmd_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  ack_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  err_timeout;

  // arbiter view
  modport slave (
    input  req_m1, cmd_m1, addr_m1, wdata_m1,
    input  req_m2, cmd_m2, addr_m2, wdata_m2,
    input  ack_s, rdata_s,
    output ack_m1, rdata_m1, ack_m2, rdata_m2,
    output req_s, cmd_s, addr_s, wdata_s, err_timeout
  );

  // environment view (masters + slave model)
  modport master (
    output req_m1, cmd_m1, addr_m1, wdata_m1,
    output req_m2, cmd_m2, addr_m2, wdata_m2,
    output ack_s, rdata_s,
    input  ack_m1, rdata_m1, ack_m2, rdata_m2,
    input  req_s, cmd_s, addr_s, wdata_s, err_timeout
  );
endinterface

// File: rtl/fsm_slave_arb.sv
// Slave-side port of the 2x2 crossbar: round-robin arbitration of two
// masters onto one slave, registered read data back to the winner and a
// watchdog that force-completes a hung slave access with an error.
module fsm_slave_arb #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 4,
  parameter int unsigned           TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hFFFF_FFFF
) (
  input  logic                clock,
  input  logic                reset_n,
  fsm_slave_arb_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, GNT_M1, GNT_M2} state_t;

  // command captured on grant entry, held stable while req_s is high
  typedef struct packed {
    logic                  cmd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t                state_q, state_d;
  logic                  last_m2_q;   // 1: master 2 held the last grant
  logic [15:0]           cnt_q;
  cmd_t                  cap_q;
  logic [DATA_WIDTH-1:0] rdata_m1_q, rdata_m2_q;

  logic                  timeout_hit;
  logic                  ack_m1, ack_m2;
  logic                  req_s, cmd_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  cmd_t req1, req2;
  assign req1 = '{cmd: bus.cmd_m1, addr: bus.addr_m1, wdata: bus.wdata_m1};
  assign req2 = '{cmd: bus.cmd_m2, addr: bus.addr_m2, wdata: bus.wdata_m2};

  // next state, slave-side drive and completion decode
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    ack_m1      = 1'b0;
    ack_m2      = 1'b0;
    req_s       = 1'b0;
    cmd_s       = 1'b0;
    addr_s      = '0;
    wdata_s     = '0;
    case (state_q)
      IDLE: begin
        // tie goes to whoever did not win last time; ack_s is ignored here
        if (bus.req_m1 && (!bus.req_m2 || last_m2_q)) state_d = GNT_M1;
        else if (bus.req_m2)                          state_d = GNT_M2;
      end
      GNT_M1, GNT_M2: begin
        req_s   = 1'b1;
        cmd_s   = cap_q.cmd;
        addr_s  = cap_q.addr;
        wdata_s = cap_q.wdata;
        // a real ack on the expiry cycle takes priority over the timeout
        timeout_hit = TO_EN && !bus.ack_s && (cnt_q == TO_LAST);
        ack_m1 = (state_q == GNT_M1) && (bus.ack_s || timeout_hit);
        ack_m2 = (state_q == GNT_M2) && (bus.ack_s || timeout_hit);
        if (bus.ack_s || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // grant capture, watchdog counter and returned read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_m2_q  <= 1'b1;
      cnt_q      <= '0;
      cap_q      <= '0;
      rdata_m1_q <= '0;
      rdata_m2_q <= '0;
    end else if (state_q == IDLE) begin
      if (state_d != IDLE) begin
        cap_q     <= (state_d == GNT_M1) ? req1 : req2;
        cnt_q     <= '0;
        last_m2_q <= (state_d == GNT_M2);
      end
    end else if (bus.ack_s) begin
      // writes leave the master's read data untouched
      if (!cap_q.cmd) begin
        if (state_q == GNT_M1) rdata_m1_q <= bus.rdata_s;
        else                   rdata_m2_q <= bus.rdata_s;
      end
    end else if (timeout_hit) begin
      if (state_q == GNT_M1) rdata_m1_q <= ERR_DATA;
      else                   rdata_m2_q <= ERR_DATA;
    end else if (TO_EN) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.ack_m1      = ack_m1;
  assign bus.ack_m2      = ack_m2;
  assign bus.rdata_m1    = rdata_m1_q;
  assign bus.rdata_m2    = rdata_m2_q;
  assign bus.req_s       = req_s;
  assign bus.cmd_s       = cmd_s;
  assign bus.addr_s      = addr_s;
  assign bus.wdata_s     = wdata_s;
  assign bus.err_timeout = timeout_hit;

endmodule
